pwm_capture: RTL and testbench

Measures the duty cycle of an incoming PWM waveform and reports it as an integer percentage 0–100, the same encoding the PWM generator accepts on its duty-cycle input. It sits on the input side of the PWM subsystem as a feedback or monitor path: a pin or a loopback of the generator output enters here, and a 7-bit duty value with a one-cycle valid strobe leaves here for the AXI register block. A generator output (period 100, duty D) fed back through this block must read back exactly D.

---
 rtl/pwm_capture.sv | 186 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Measures PWM period and duty (0-100 %) with a stuck-input timeout.
//            Optional 3-sample glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN
// Revision : 1.0  initial release
// ============================================================================
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [6:0]       duty_cycle,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period,
    output logic             stuck,
    output logic             overrun
);
    localparam int c_DIV_W  = CNT_W + 7;
    localparam int c_STEP_W = $clog2(c_DIV_W + 1);
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(c_DIV_W - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MEAS = 1'b1} state_t;

    state_t r_state, w_state_nxt;

    logic r_sync1, r_sync2, r_lvl_d;
    logic w_lvl, w_rise;
    logic w_accept, w_drop, w_timeout;

    logic [CNT_W-1:0]   r_cnt_p, r_cnt_h;
    logic               r_busy;
    logic [c_STEP_W-1:0] r_step;
    logic [c_DIV_W-1:0] r_quo;
    logic [CNT_W-1:0]   r_rem, r_dvsr;

    logic [c_DIV_W-1:0] w_h_x100, w_quo_nxt;
    logic [CNT_W:0]     w_rem_sh;
    logic [CNT_W-1:0]   w_diff, w_rem_nxt;
    logic               w_ge, w_last, w_div_free;
    logic [6:0]         w_res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_lvl_d <= w_lvl;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Level follows the synchronizer only once three consecutive samples agree
    logic r_hist1, r_hist2, r_filt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_filt  <= w_lvl;
        end
    end

    assign w_lvl = ((r_sync2 == r_hist1) && (r_hist1 == r_hist2)) ? r_sync2 : r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_rise = w_lvl & ~r_lvl_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_nxt = S_MEAS;
            end
            S_MEAS: begin
                if (w_rise) begin
                    if (w_div_free) w_accept = 1'b1;
                    else            w_drop   = 1'b1;
                end else if (r_cnt_p == '1) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_p <= '0;
            r_cnt_h <= '0;
        end else if (w_rise) begin
            r_cnt_p <= CNT_W'(1);
            r_cnt_h <= CNT_W'(w_lvl);
        end else if (r_state == S_MEAS) begin
            if (r_cnt_p != '1)           r_cnt_p <= r_cnt_p + CNT_W'(1);
            if (w_lvl && r_cnt_h != '1)  r_cnt_h <= r_cnt_h + CNT_W'(1);
        end
    end

    // Restoring divider; dividend bits shift out of r_quo as quotient bits shift in
    assign w_h_x100   = c_DIV_W'(r_cnt_h) * c_DIV_W'(100);
    assign w_rem_sh   = {r_rem, r_quo[c_DIV_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_diff     = w_rem_sh[CNT_W-1:0] - r_dvsr;
    assign w_rem_nxt  = w_ge ? w_diff : w_rem_sh[CNT_W-1:0];
    assign w_quo_nxt  = {r_quo[c_DIV_W-2:0], w_ge};
    assign w_last     = r_busy && (r_step == c_LAST_STEP);
    assign w_div_free = !r_busy || w_last;

    always_comb begin
        w_res = w_quo_nxt[6:0];
        if (r_dvsr == '0)                       w_res = 7'd0;
        else if (w_quo_nxt > c_DIV_W'(100))     w_res = 7'd100;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_step <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_step <= '0;
            r_quo  <= w_h_x100;
            r_rem  <= '0;
            r_dvsr <= r_cnt_p;
        end else if (w_timeout) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_quo  <= w_quo_nxt;
            r_rem  <= w_rem_nxt;
            r_step <= r_step + c_STEP_W'(1);
            if (w_last) r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_cycle <= 7'd0;
            duty_valid <= 1'b0;
            period     <= '0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (w_rise) stuck <= 1'b0;
            if (w_drop) overrun <= 1'b1;
            if (w_timeout) begin
                duty_cycle <= w_lvl ? 7'd100 : 7'd0;
                period     <= '1;
                duty_valid <= 1'b1;
                stuck      <= 1'b1;
            end else if (w_last) begin
                duty_cycle <= w_res;
                period     <= r_dvsr;
                duty_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Directed self-checking bench for pwm_capture (CNT_W = 10).
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;
    localparam int CNT_W = 10;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int c_SYNC = 4;
`else
    localparam int c_SYNC = 2;
`endif
    // pwm_in drive to duty_valid: input latency plus CNT_W+8
    localparam int c_LAT = c_SYNC + CNT_W + 8;

    logic             clk;
    logic             rst_n;
    logic             pwm_in;
    logic [6:0]       duty_cycle;
    logic             duty_valid;
    logic [CNT_W-1:0] period;
    logic             stuck;
    logic             overrun;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_strb = 0;
    int s_duty = 0;
    int s_period = 0;
    int s_cyc  = 0;
    int last_rise = 0;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .duty_valid (duty_valid),
        .period     (period),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (duty_valid === 1'b1) begin
            n_strb++;
            s_duty   = 32'(duty_cycle);
            s_period = 32'(period);
            s_cyc    = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            pwm_in    = 1'b1;
            last_rise = cyc;
            repeat (hi) tick();
            pwm_in = 1'b0;
            repeat (per - hi) tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) tick();
        check("rst_duty",    32'(duty_cycle), 32'd0);
        check("rst_valid",   32'(duty_valid), 32'd0);
        check("rst_period",  32'(period),     32'd0);
        check("rst_stuck",   32'(stuck),      32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 100/37: first edge gives nothing, then one strobe per period
        n_strb = 0;
        run(100, 37, 1);
        check("p100_first_nostrobe", n_strb, 0);
        run(100, 37, 3);
        check("p100_count",  n_strb,   3);
        check("p100_duty",   s_duty,   37);
        check("p100_period", s_period, 100);
        check("p100_latency", s_cyc - last_rise, c_LAT);

        n_strb = 0;
        run(200, 50, 3);
        check("p200_count",  n_strb,   3);
        check("p200_duty",   s_duty,   25);
        check("p200_period", s_period, 200);

        run(302, 299, 3);
        check("p302_duty_floor", s_duty,   99);
        check("p302_period",     s_period, 302);
        check("p302_stuck",      32'(stuck),   32'd0);
        check("p302_overrun",    32'(overrun), 32'd0);

        // Period 10: accepted at rises 1,3,5; rises 2,4,6 dropped
        n_strb = 0;
        run(10, 5, 6);
        repeat (5) tick();
        check("p10_count",   n_strb,   3);
        check("p10_duty",    s_duty,   50);
        check("p10_period",  s_period, 10);
        check("p10_overrun", 32'(overrun), 32'd1);

        run(100, 37, 2);
        repeat (25) tick();
        check("sticky_overrun", 32'(overrun), 32'd1);
        check("after_ovr_duty", s_duty, 37);

        // Reset five cycles into a division
        pwm_in = 1'b1;
        repeat (c_SYNC + 1 + 5) tick();
        n_strb = 0;
        rst_n  = 1'b0;
        repeat (2) tick();
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        repeat (40) tick();
        check("middiv_nostrobe", n_strb, 0);
        check("middiv_duty",    32'(duty_cycle), 32'd0);
        check("middiv_period",  32'(period),     32'd0);
        check("middiv_stuck",   32'(stuck),      32'd0);
        check("middiv_overrun", 32'(overrun),    32'd0);

        // Timeout with input low
        pwm_in = 1'b1;
        repeat (5) tick();
        pwm_in = 1'b0;
        n_strb = 0;
        repeat (1040) tick();
        check("tmo_lo_count",  n_strb,   1);
        check("tmo_lo_duty",   s_duty,   0);
        check("tmo_lo_period", s_period, 1023);
        check("tmo_lo_stuck",  32'(stuck), 32'd1);

        // Timeout with input high; the edge first clears stuck
        pwm_in = 1'b1;
        repeat (c_SYNC + 3) tick();
        check("tmo_hi_clear", 32'(stuck), 32'd0);
        n_strb = 0;
        repeat (1040) tick();
        check("tmo_hi_count",  n_strb,   1);
        check("tmo_hi_duty",   s_duty,   100);
        check("tmo_hi_period", s_period, 1023);
        check("tmo_hi_stuck",  32'(stuck), 32'd1);

        pwm_in = 1'b0;
        repeat (5) tick();
        pwm_in = 1'b1;
        repeat (c_SYNC + 3) tick();
        check("edge_clears_stuck", 32'(stuck), 32'd0);
        check("duty_holds",        32'(duty_cycle), 32'd100);

        // 1-cycle glitch in the low phase of a 100/40 stream
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        run(100, 40, 2);
        n_strb = 0;
        pwm_in = 1'b1;
        repeat (40) tick();
        pwm_in = 1'b0;
        repeat (30) tick();
        pwm_in = 1'b1;
        tick();
        pwm_in = 1'b0;
        repeat (29) tick();
        run(100, 40, 1);
        repeat (5) tick();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check("glitch_count",  n_strb,   2);
        check("glitch_duty",   s_duty,   40);
        check("glitch_period", s_period, 100);
`else
        check("glitch_count",  n_strb,   3);
        check("glitch_duty",   s_duty,   3);
        check("glitch_period", s_period, 30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
